// File: rtl/ram512x64_arbiter_if.sv
// One requester port of the RAM arbiter: request fields out, grant and read response back.
interface ram512x64_arbiter_if;
  logic        req;
  logic [7:0]  we;
  logic [8:0]  a;
  logic [63:0] di;
  logic        gnt;
  logic        rvalid;
  logic [63:0] dout;

  modport master (output req, we, a, di, input gnt, rvalid, dout);
  modport slave  (input req, we, a, di, output gnt, rvalid, dout);
endinterface

// File: rtl/ram512x64_arbiter.sv
// Two-requester arbiter plus zero-fill sequencer in front of a 512x64 single-cycle RAM.
// Read data is routed back to whichever requester was granted the read.
module ram512x64_arbiter #(
  parameter bit          FIXED_PRIO   = 1'b0,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ram512x64_arbiter_if.slave          r0,
  ram512x64_arbiter_if.slave          r1,
  input  logic                        clr_start,
  output logic                        busy,
  output logic                        clr_done,
  output logic                        ram_en,
  output logic [7:0]                  ram_we,
  output logic [8:0]                  ram_a,
  output logic [63:0]                 ram_di,
  input  logic [63:0]                 ram_do
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state, state_nxt;
  logic [8:0]  clr_addr;
  logic        rr_r1_next;   // round-robin: 1 when R1 holds priority
  logic [3:0]  starve_cnt;
  logic        rv0_q, rv1_q, clr_done_q;
  logic        g0, g1;

  // State and bookkeeping registers; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here sees pre-edge values.
    if (!rst_n) begin
      state      <= IDLE;
      clr_addr   <= '0;
      rr_r1_next <= 1'b0;
      starve_cnt <= '0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_addr   <= (state == CLEAR) ? clr_addr + 9'd1 : '0;
      clr_done_q <= (state == CLEAR) && (clr_addr == 9'd511);
      rv0_q      <= g0 && (r0.we == '0);
      rv1_q      <= g1 && (r1.we == '0);

      if (g0)      rr_r1_next <= 1'b1;
      else if (g1) rr_r1_next <= 1'b0;

      if (g1 || !r1.req)          starve_cnt <= '0;
      else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_start)             state_nxt = CLEAR;
      CLEAR:   if (clr_addr == 9'd511)    state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_comb begin
    logic arb_en;
    // NOTE: every output gets a default first so no path can infer a latch.
    g0     = 1'b0;
    g1     = 1'b0;
    ram_en = 1'b0;
    ram_we = '0;
    ram_a  = '0;
    ram_di = '0;
    busy   = (state == CLEAR);

    // A clear request pre-empts arbitration in its own cycle.
    arb_en = rst_n && (state == IDLE) && !clr_start;
    if (FIXED_PRIO)
      g1 = arb_en && r1.req && (!r0.req || (starve_cnt == LIMIT));
    else
      g1 = arb_en && r1.req && (!r0.req || rr_r1_next);
    g0 = arb_en && r0.req && !g1;

    if (state == CLEAR) begin
      ram_en = 1'b1;
      ram_we = 8'hFF;
      ram_a  = clr_addr;
    end else if (g0) begin
      ram_en = 1'b1;
      ram_we = r0.we;
      ram_a  = r0.a;
      ram_di = r0.di;
    end else if (g1) begin
      ram_en = 1'b1;
      ram_we = r1.we;
      ram_a  = r1.a;
      ram_di = r1.di;
    end
  end

  // A reset in the response cycle suppresses a pending read response.
  assign r0.gnt    = g0;
  assign r1.gnt    = g1;
  assign r0.rvalid = rv0_q && rst_n;
  assign r1.rvalid = rv1_q && rst_n;
  assign r0.dout   = ram_do;
  assign r1.dout   = ram_do;
  assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_ram512x64_arbiter.sv
// Directed bench: round-robin and fixed-priority instances, each with a behavioural RAM,
// read responses checked against a reference memory through per-port scoreboards.
module tb_ram512x64_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clr_start, fp_clr_start;
  logic        busy, clr_done, ram_en, fp_busy, fp_clr_done, fp_en;
  logic [7:0]  ram_we, fp_we;
  logic [8:0]  ram_a, fp_a;
  logic [63:0] ram_di, ram_do, fp_di, fp_do;

  ram512x64_arbiter_if m0 ();
  ram512x64_arbiter_if m1 ();
  ram512x64_arbiter_if f0 ();
  ram512x64_arbiter_if f1 ();

  ram512x64_arbiter #(.FIXED_PRIO(1'b0), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .r0(m0), .r1(m1), .clr_start(clr_start),
    .busy(busy), .clr_done(clr_done), .ram_en(ram_en), .ram_we(ram_we),
    .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do));

  ram512x64_arbiter #(.FIXED_PRIO(1'b1), .STARVE_LIMIT(4)) dut_fp (
    .clk(clk), .rst_n(rst_n), .r0(f0), .r1(f1), .clr_start(fp_clr_start),
    .busy(fp_busy), .clr_done(fp_clr_done), .ram_en(fp_en), .ram_we(fp_we),
    .ram_a(fp_a), .ram_di(fp_di), .ram_do(fp_do));

  logic [63:0] mem_rr [512];
  logic [63:0] mem_fp [512];
  logic [63:0] ref_mem [512];
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  int checks = 0;
  int errors = 0;

  always @(posedge clk) begin
    if (ram_en) begin
      for (int i = 0; i < 8; i++)
        if (ram_we[i]) mem_rr[ram_a][8*i +: 8] <= ram_di[8*i +: 8];
      ram_do <= mem_rr[ram_a];
    end
    if (fp_en) begin
      for (int i = 0; i < 8; i++)
        if (fp_we[i]) mem_fp[fp_a][8*i +: 8] <= fp_di[8*i +: 8];
      fp_do <= mem_fp[fp_a];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] di,
                                        input logic [7:0] we);
    logic [63:0] r = old;
    for (int i = 0; i < 8; i++)
      if (we[i]) r[8*i +: 8] = di[8*i +: 8];
    return r;
  endfunction

  // Response monitor: every RVALID must match the oldest outstanding read of that port.
  always @(negedge clk) begin
    if (m0.rvalid === 1'b1) begin
      if (q0.size() == 0) check("r0_rvalid_unexpected", 64'(m0.rvalid), 64'd0);
      else                check("r0_rdata", m0.dout, q0.pop_front());
    end
    if (m1.rvalid === 1'b1) begin
      if (q1.size() == 0) check("r1_rvalid_unexpected", 64'(m1.rvalid), 64'd0);
      else                check("r1_rdata", m1.dout, q1.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-requester access, expected to be granted in the cycle it is presented.
  task automatic acc(input bit who, input logic [7:0] we, input logic [8:0] a,
                     input logic [63:0] di);
    if (!who) begin
      m0.req = 1'b1; m0.we = we; m0.a = a; m0.di = di;
    end else begin
      m1.req = 1'b1; m1.we = we; m1.a = a; m1.di = di;
    end
    if (we == 8'h00) begin
      if (!who) q0.push_back(ref_mem[a]);
      else      q1.push_back(ref_mem[a]);
    end else begin
      ref_mem[a] = merge(ref_mem[a], di, we);
    end
    @(negedge clk);
    check(who ? "r1_gnt" : "r0_gnt", 64'(who ? m1.gnt : m0.gnt), 64'd1);
    check(who ? "r0_gnt_idle" : "r1_gnt_idle", 64'(who ? m0.gnt : m1.gnt), 64'd0);
    tick();
    m0.req = 1'b0;
    m1.req = 1'b0;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
  endtask

  initial begin
    int nogrant, busy_n, done_n;
    for (int i = 0; i < 512; i++) begin
      mem_rr[i] = '0; mem_fp[i] = '0; ref_mem[i] = '0;
    end
    rst_n = 1'b0; clr_start = 1'b0; fp_clr_start = 1'b0;
    m0.req = 0; m0.we = '0; m0.a = '0; m0.di = '0;
    m1.req = 0; m1.we = '0; m1.a = '0; m1.di = '0;
    f0.req = 0; f0.we = '0; f0.a = '0; f0.di = '0;
    f1.req = 0; f1.we = '0; f1.a = '0; f1.di = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_r0_gnt", 64'(m0.gnt), 64'd0);
    check("rst_r1_gnt", 64'(m1.gnt), 64'd0);
    check("rst_r0_rvalid", 64'(m0.rvalid), 64'd0);
    check("rst_r1_rvalid", 64'(m1.rvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_clr_done", 64'(clr_done), 64'd0);
    check("rst_ram_en", 64'(ram_en), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single-requester write then read.
    acc(0, 8'hFF, 9'd5, 64'hDEAD_BEEF_0123_4567);
    acc(0, 8'h00, 9'd5, '0);
    tick();

    // Byte-lane merge on R1.
    acc(1, 8'hFF, 9'd9, 64'h0);
    acc(1, 8'h0F, 9'd9, 64'hFFFF_FFFF_FFFF_FFFF);
    acc(1, 8'h00, 9'd9, '0);
    tick();

    // Round-robin with both requesters holding reads; R1 was granted last.
    acc(0, 8'hFF, 9'd1, 64'h1111_2222_3333_4444);
    acc(1, 8'hFF, 9'd2, 64'h5555_6666_7777_8888);
    m0.req = 1; m0.we = '0; m0.a = 9'd1;
    m1.req = 1; m1.we = '0; m1.a = 9'd2;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) q0.push_back(ref_mem[1]);
      else            q1.push_back(ref_mem[2]);
      @(negedge clk);
      check($sformatf("rr_r0_gnt_%0d", i), 64'(m0.gnt), 64'(i % 2 == 0));
      check($sformatf("rr_r1_gnt_%0d", i), 64'(m1.gnt), 64'(i % 2 == 1));
      tick();
    end
    m0.req = 0; m1.req = 0;
    tick();

    // Fixed priority with starvation relief after four blocked R1 cycles.
    f0.req = 1; f0.a = 9'd3;
    f1.req = 1; f1.a = 9'd4;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("fp_r0_gnt_%0d", i), 64'(f0.gnt), 64'(i != 4));
      check($sformatf("fp_r1_gnt_%0d", i), 64'(f1.gnt), 64'(i == 4));
      tick();
    end
    f0.req = 0; f1.req = 0;

    // Clear colliding with a pending R0 read; a second pulse mid-clear is ignored.
    acc(0, 8'hFF, 9'd0,   64'hA5A5_0000_0000_0001);
    acc(0, 8'hFF, 9'd255, 64'hA5A5_0000_0000_00FF);
    acc(0, 8'hFF, 9'd511, 64'hA5A5_0000_0000_01FF);
    m0.req = 1; m0.we = '0; m0.a = 9'd0;
    clr_start = 1'b1;
    clear_ref();
    nogrant = 0; busy_n = 0; done_n = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (m0.gnt) break;
      nogrant++;
      busy_n += int'(busy);
      done_n += int'(clr_done);
      tick();
      clr_start = (nogrant == 50);
    end
    clr_start = 1'b0;
    check("clr_done_at_grant", 64'(clr_done), 64'd1);
    check("busy_at_grant", 64'(busy), 64'd0);
    check("clr_nogrant_cycles", 64'(nogrant), 64'd513);
    check("clr_busy_cycles", 64'(busy_n), 64'd512);
    check("clr_done_early", 64'(done_n), 64'd0);
    q0.push_back(ref_mem[0]);
    tick();
    m0.req = 0;
    acc(0, 8'h00, 9'd255, '0);
    acc(0, 8'h00, 9'd511, '0);

    // Read granted just before CLR_START, then reset at clear cycle 100.
    acc(0, 8'hFF, 9'd300, 64'h0BAD_CAFE_0000_012C);
    acc(0, 8'h00, 9'd300, '0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (99) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    done_n = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      done_n += int'(clr_done);
      tick();
    end
    check("abort_no_done", 64'(done_n), 64'd0);

    clear_ref();
    clr_start = 1'b1;
    busy_n = 0; done_n = 0;
    for (int n = 0; n < 520; n++) begin
      @(negedge clk);
      busy_n += int'(busy);
      done_n += int'(clr_done);
      tick();
      clr_start = 1'b0;
    end
    check("reclr_busy_cycles", 64'(busy_n), 64'd512);
    check("reclr_done_pulses", 64'(done_n), 64'd1);
    acc(0, 8'h00, 9'd300, '0);
    tick();

    // Reset in the response cycle suppresses RVALID.
    m0.req = 1; m0.we = '0; m0.a = 9'd300;
    @(negedge clk);
    check("pre_rst_gnt", 64'(m0.gnt), 64'd1);
    tick();
    m0.req = 0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_rvalid_suppressed", 64'(m0.rvalid), 64'd0);
    tick();
    rst_n = 1'b1;

    repeat (3) tick();
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram512x64_arbiter.md
Name: ram512x64_arbiter

Overview:
- Two-requester arbiter and clear sequencer in front of one RAM_512x64 instance (512 words x 64 bits, 8 byte lanes, single-cycle access).
- Shares the RAM between two masters, for example a CPU load/store port and a DMA/debug port.
- Routes each read response back to the requester that issued it.
- Provides a hardware clear that zero-fills the whole RAM.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin; 1 = R0 has fixed priority, with starvation relief for R1.
- STARVE_LIMIT, 4, in FIXED_PRIO mode: number of consecutive blocked R1 cycles after which R1 is forced a grant (range 1..15).

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  synchronous reset, active low
- R0_REQ  in  1  requester 0 access request
- R0_WE  in  8  byte write enables; 0 = read
- R0_A  in  9  word address
- R0_DI  in  64  write data
- R0_GNT  out  1  access accepted this cycle
- R0_RVALID  out  1  read data valid
- R0_DO  out  64  read data
- R1_REQ, R1_WE, R1_A, R1_DI, R1_GNT, R1_RVALID, R1_DO: identical to the R0 ports, for requester 1
- CLR_START  in  1  one-cycle pulse; starts a zero-fill of all 512 words
- BUSY  out  1  clear in progress
- CLR_DONE  out  1  one-cycle pulse after the final clear write
- RAM_EN  out  1  to RAM EN
- RAM_WE  out  8  to RAM WE
- RAM_A  out  9  to RAM A
- RAM_DI  out  64  to RAM Di
- RAM_DO  in  64  from RAM Do

Behaviour:
- RAM timing contract: the RAM samples EN/WE/A/Di on the CLK edge. Read data appears on RAM_DO in the following cycle.
- States: IDLE and CLEAR.
- Reset values: state=IDLE, RR pointer favours R0, starvation counter=0, clear address=0. All outputs are 0: GNT, RVALID, BUSY, CLR_DONE, RAM_EN, RAM_WE.
- GNT is combinational in IDLE.
  - A requester is granted in the same cycle REQ is high and it wins arbitration.
  - Its WE/A/DI drive the RAM ports that cycle, and RAM_EN=1.
  - At most one GNT per cycle.
  - A requester holds REQ and its fields stable until GNT.
- No request in IDLE: RAM_EN=0, RAM_WE=0.
- Round-robin (FIXED_PRIO=0):
  - A single requester always wins.
  - If both request, the one not granted most recently wins.
  - The pointer updates only on a grant.
- Fixed priority (FIXED_PRIO=1):
  - R0 wins by default.
  - The counter increments each cycle R1_REQ=1 and R1 is not granted, saturating at STARVE_LIMIT.
  - The counter clears when R1 is granted or when R1_REQ=0.
  - When counter==STARVE_LIMIT and R1_REQ=1, R1 wins over R0.
- Read responses:
  - A grant with WE==0 produces Rx_RVALID=1 for exactly one cycle, in the cycle after the grant, with Rx_DO=RAM_DO.
  - Writes (any WE bit set) produce no RVALID.
  - Rx_DO is don't-care when RVALID=0.
  - The unselected requester's RVALID stays 0.
- CLR_START when in IDLE:
  - No GNT is given in the CLR_START cycle.
  - State becomes CLEAR at the next edge.
  - CLR_START in the same cycle as REQ: clear wins and the requests wait.
- CLEAR state:
  - BUSY=1.
  - Each cycle: RAM_EN=1, RAM_WE=8'hFF, RAM_DI=0, RAM_A=clear address. The address increments from 0 to 511, 512 cycles total.
  - No GNT is given during CLEAR.
  - After writing address 511, return to IDLE; CLR_DONE=1 for one cycle and BUSY=0 in that cycle.
  - Grants resume in that same cycle.
- CLR_START while BUSY: ignored.
- A read granted in the cycle before CLR_START still delivers its RVALID on schedule, in the CLR_START cycle.
- Reset mid-clear: the clear aborts, state returns to IDLE, BUSY=0, and no CLR_DONE. RAM contents are unspecified.
- Reset in the cycle after a read grant: RVALID is suppressed (0).

Test Plan:
- Write then read, single requester: R0 writes 64'hDEAD_BEEF_0123_4567 to A=5 with WE=FF, then reads A=5 → R0_GNT in the same cycle each time; R0_RVALID the cycle after the read with that data; R1_RVALID stays 0.
- Byte lanes: R1 writes 64'h0 with FF to A=9, then 64'hFFFF_FFFF_FFFF_FFFF with WE=8'h0F, then reads → R1_DO=64'h0000_0000_FFFF_FFFF.
- Round-robin, FIXED_PRIO=0: both requesters hold reads to A=1 (R0) and A=2 (R1) continuously for 6 cycles → grants alternate R0,R1,R0,R1,R0,R1; each RVALID returns the correct word to the correct port.
- Starvation, FIXED_PRIO=1, STARVE_LIMIT=4: both requesters hold REQ → R0 granted 4 cycles, R1 granted on cycle 5, then R0 granted again.
- Clear: fill A=0, 255 and 511 with nonzero data, pulse CLR_START while R0_REQ=1 →
  - no GNT for 513 cycles, BUSY=1 for 512 cycles;
  - CLR_DONE pulses once and R0 is granted in that same cycle;
  - subsequent reads of A=0, 255 and 511 return 0.
- Reset mid-clear: assert RST_N=0 at clear cycle 100 for 1 cycle → BUSY=0, no CLR_DONE; a new CLR_START performs a full 512-cycle clear.
